// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressable load/store initiator with split misaligned beats
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata0_q;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd1:    size_mask = 4'b0011;
            2'd2:    size_mask = 4'b0001;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [63:0] pair, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'd1:    load_result = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'd2:    load_result = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            default: load_result = sh;
        endcase
    endfunction

    // Second-beat lanes are whatever spills past byte 3 of the first word.
    logic [1:0]  off_q;
    logic [3:0]  be1_q;
    logic [31:0] wdata1_q;
    logic [31:0] addr1_q;
    logic        split_q;

    assign off_q    = addr_q[1:0];
    assign be1_q    = size_mask(size_q) >> (3'd4 - {1'b0, off_q});
    assign wdata1_q = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
    assign addr1_q  = {addr_q[31:2], 2'b00} + 32'd4;
    assign split_q  = |be1_q;

    assign req_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata0_q   <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        mem_valid <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= size_mask(req_size) << req_addr[1:0];
                        mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                        state     <= REQ0;
                    end
                end
                REQ0: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            mem_valid <= 1'b0;
                            state     <= WAIT0;
                        end else if (split_q) begin
                            mem_addr  <= addr1_q;
                            mem_be    <= be1_q;
                            mem_wdata <= wdata1_q;
                            state     <= REQ1;
                        end else begin
                            mem_valid  <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= RESP;
                        end
                    end
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        rdata0_q <= mem_rdata;
                        if (split_q) begin
                            mem_valid <= 1'b1;
                            mem_addr  <= addr1_q;
                            mem_be    <= be1_q;
                            mem_wdata <= wdata1_q;
                            state     <= REQ1;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= load_result({32'd0, mem_rdata}, off_q, size_q, uns_q);
                            state      <= RESP;
                        end
                    end
                end
                REQ1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!we_q) begin
                            state <= WAIT1;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= RESP;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_result({mem_rdata, rdata0_q}, off_q, size_q, uns_q);
                        state      <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int c;} beat_t;
    typedef struct {logic [31:0] data; int cnt;} rd_t;
    typedef struct {int c; logic [31:0] data;} resp_t;

    beat_t beats[$];
    rd_t   rdq[$];
    resp_t resps[$];
    logic [7:0] dut_mem [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];
    int stall_left = 0;
    bit rand_ready = 1'b0;
    int lat_fixed = -1;
    int last_rvalid_cyc = 0;

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return (a[7:0] ^ a[15:8]) + 8'h3C;
    endfunction
    function automatic logic [7:0] rd_dut(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : def_byte(a);
    endfunction
    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_byte(a);
    endfunction
    function automatic void preset_word(input logic [31:0] wa, input logic [31:0] w);
        for (int j = 0; j < 4; j++) begin
            dut_mem[wa + j] = w[8*j +: 8];
            ref_mem[wa + j] = w[8*j +: 8];
        end
    endfunction

    // Reference model: a request touches bytes addr .. addr+n-1 (mod 2^32).
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 4;
    endfunction
    function automatic int exp_nbeats(input logic [31:0] a, input logic [1:0] size);
        logic [31:0] last;
        last = a + nbytes(size) - 1;
        return (last[31:2] != a[31:2]) ? 2 : 1;
    endfunction
    function automatic logic [31:0] exp_baddr(input logic [31:0] a, input int k);
        return {a[31:2], 2'b00} + 4 * k;
    endfunction
    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] size, input int k);
        logic [31:0] d;
        logic [3:0]  be;
        be = 4'd0;
        for (int j = 0; j < 4; j++) begin
            d = exp_baddr(a, k) + j - a;
            if (d < nbytes(size)) be[j] = 1'b1;
        end
        return be;
    endfunction
    function automatic logic [31:0] exp_lanes(input logic [31:0] a, input logic [1:0] size,
                                              input logic [31:0] wd, input int k);
        logic [31:0] d;
        logic [31:0] v;
        v = 32'd0;
        for (int j = 0; j < 4; j++) begin
            d = exp_baddr(a, k) + j - a;
            if (d < nbytes(size)) v[8*j +: 8] = wd[8*d[1:0] +: 8];
        end
        return v;
    endfunction
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v;
        n = nbytes(size);
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_ref(a + i);
        if (n != 4 && !uns && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction
    function automatic void ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
        for (int i = 0; i < nbytes(size); i++) ref_mem[a + i] = wd[8*i +: 8];
    endfunction

    // Memory responder: drives ready/rvalid at negedge and logs each accepted beat.
    initial forever begin
        @(negedge clk);
        if (rdq.size() > 0 && rdq[0].cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdq[0].data;
            last_rvalid_cyc = cyc;
            void'(rdq.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (rdq.size() > 0) rdq[0].cnt = rdq[0].cnt - 1;
        end
        if (mem_valid && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (mem_valid && mem_ready && rst_n) begin
            beats.push_back('{mem_we, mem_addr, mem_be, mem_wdata, cyc});
            if (mem_we) begin
                for (int j = 0; j < 4; j++)
                    if (mem_be[j]) dut_mem[mem_addr + j] = mem_wdata[8*j +: 8];
            end else begin
                logic [31:0] w;
                for (int j = 0; j < 4; j++) w[8*j +: 8] = rd_dut(mem_addr + j);
                rdq.push_back('{w, (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 2)});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (resp_valid) resps.push_back('{cyc, resp_rdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] size, input logic uns, output int hs_c);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got 0 want 1");
        end
        req_we = we; req_addr = a; req_wdata = wd; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        hs_c = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_we = $urandom; req_size = $urandom;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output int rs_c);
        int k;
        k = 0;
        while (resps.size() == 0 && k < 200) begin
            tick();
            k++;
        end
        if (resps.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: got no resp_valid want one");
            rd = 32'hxxxxxxxx;
            rs_c = -1;
        end else begin
            rd = resps[0].data;
            rs_c = resps[0].c;
            void'(resps.pop_front());
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rd, output int hs_c, output int rs_c);
        beats.delete();
        drive_req(we, a, wd, size, uns, hs_c);
        wait_resp(rd, rs_c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({req_ready, resp_valid, resp_rdata, mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h mv=%b we=%b a=%h be=%b wd=%h want all 0",
                         req_ready, resp_valid, resp_rdata, mem_valid, mem_we, mem_addr, mem_be, mem_wdata);
            end
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_aligned_store();
        logic [31:0] rd;
        int hs, rs;
        rand_ready = 1'b0;
        do_req(1'b1, 32'h100, 32'hDEADBEEF, 2'd0, 1'b0, rd, hs, rs);
        ref_store(32'h100, 2'd0, 32'hDEADBEEF);
        n_cmp++;
        if (beats.size() !== 1) begin
            n_bad++;
            $display("FAIL sw_nbeats: got %0d want 1", beats.size());
        end else begin
            n_cmp++;
            if ({beats[0].we, beats[0].addr, beats[0].be, beats[0].wdata} !== {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
                n_bad++;
                $display("FAIL sw_beat: got we=%b a=%h be=%b wd=%h want we=1 a=00000100 be=1111 wd=deadbeef",
                         beats[0].we, beats[0].addr, beats[0].be, beats[0].wdata);
            end
        end
        n_cmp++;
        if (rs - hs !== 2) begin
            n_bad++;
            $display("FAIL sw_latency: got %0d want 2", rs - hs);
        end
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL sw_rdata: got %h want 00000000", rd);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd;
        int hs, rs;
        do_req(1'b1, 32'h203, 32'h000000A5, 2'd2, 1'b0, rd, hs, rs);
        ref_store(32'h203, 2'd2, 32'h000000A5);
        n_cmp++;
        if (beats.size() !== 1) begin
            n_bad++;
            $display("FAIL sb_nbeats: got %0d want 1", beats.size());
        end else begin
            n_cmp++;
            if ({beats[0].addr, beats[0].be, beats[0].wdata} !== {32'h200, 4'b1000, 32'hA5000000}) begin
                n_bad++;
                $display("FAIL sb_beat: got a=%h be=%b wd=%h want a=00000200 be=1000 wd=a5000000",
                         beats[0].addr, beats[0].be, beats[0].wdata);
            end
        end
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL sb_rdata: got %h want 00000000", rd);
        end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rd;
        int hs, rs;
        preset_word(32'h200, 32'h0000F200);
        lat_fixed = 2;
        do_req(1'b0, 32'h201, 32'd0, 2'd2, 1'b0, rd, hs, rs);
        n_cmp++;
        if (rd !== 32'hFFFFFFF2) begin
            n_bad++;
            $display("FAIL lb_rdata: got %h want fffffff2", rd);
        end
        n_cmp++;
        if (rs !== last_rvalid_cyc + 1) begin
            n_bad++;
            $display("FAIL lb_latency: got resp cycle %0d want %0d", rs, last_rvalid_cyc + 1);
        end
        n_cmp++;
        if (beats.size() !== 1 || {beats[0].we, beats[0].addr, beats[0].be} !== {1'b0, 32'h200, 4'b0010}) begin
            n_bad++;
            $display("FAIL lb_beat: got n=%0d want n=1 we=0 a=00000200 be=0010", beats.size());
        end
        do_req(1'b0, 32'h201, 32'd0, 2'd2, 1'b1, rd, hs, rs);
        n_cmp++;
        if (rd !== 32'h000000F2) begin
            n_bad++;
            $display("FAIL lbu_rdata: got %h want 000000f2", rd);
        end
        lat_fixed = -1;
    endtask

    task automatic test_misaligned_load();
        logic [31:0] rd;
        int hs, rs;
        preset_word(32'h1FC, 32'h44332211);
        preset_word(32'h200, 32'h88776655);
        do_req(1'b0, 32'h1FE, 32'd0, 2'd0, 1'b0, rd, hs, rs);
        n_cmp++;
        if (beats.size() !== 2) begin
            n_bad++;
            $display("FAIL lw_split_nbeats: got %0d want 2", beats.size());
        end else begin
            n_cmp++;
            if ({beats[0].addr, beats[0].be, beats[1].addr, beats[1].be} !== {32'h1FC, 4'b1100, 32'h200, 4'b0011}) begin
                n_bad++;
                $display("FAIL lw_split_beats: got %h/%b %h/%b want 000001fc/1100 00000200/0011",
                         beats[0].addr, beats[0].be, beats[1].addr, beats[1].be);
            end
        end
        n_cmp++;
        if (rd !== 32'h66554433) begin
            n_bad++;
            $display("FAIL lw_split_rdata: got %h want 66554433", rd);
        end
    endtask

    task automatic test_stall_split_store();
        logic [31:0] rd;
        int hs, rs;
        rand_ready = 1'b0;
        stall_left = 3;
        beats.delete();
        drive_req(1'b1, 32'hFFFFFFFF, 32'h00001234, 2'd1, 1'b0, hs);
        ref_store(32'hFFFFFFFF, 2'd1, 32'h00001234);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 32'hFFFFFFFC, 4'b1000, 32'h34000000}) begin
                n_bad++;
                $display("FAIL sh_beat0_hold[%0d]: got v=%b we=%b a=%h be=%b wd=%h want v=1 we=1 a=fffffffc be=1000 wd=34000000",
                         i, mem_valid, mem_we, mem_addr, mem_be, mem_wdata);
            end
        end
        wait_resp(rd, rs);
        n_cmp++;
        if (beats.size() !== 2) begin
            n_bad++;
            $display("FAIL sh_split_nbeats: got %0d want 2", beats.size());
        end else begin
            n_cmp++;
            if ({beats[1].we, beats[1].addr, beats[1].be, beats[1].wdata} !== {1'b1, 32'h0, 4'b0001, 32'h00000012}) begin
                n_bad++;
                $display("FAIL sh_beat1: got we=%b a=%h be=%b wd=%h want we=1 a=00000000 be=0001 wd=00000012",
                         beats[1].we, beats[1].addr, beats[1].be, beats[1].wdata);
            end
        end
        n_cmp++;
        if (rd !== 32'd0) begin
            n_bad++;
            $display("FAIL sh_rdata: got %h want 00000000", rd);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        int hs, rs;
        int spurious;
        rand_ready = 1'b0;
        lat_fixed = 4;
        beats.delete();
        drive_req(1'b0, 32'h300, 32'd0, 2'd0, 1'b0, hs);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({mem_valid, resp_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset_outputs: got mv=%b rv=%b want 0 0", mem_valid, resp_valid);
        end
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid || mem_valid) spurious++;
        end
        resps.delete();
        n_cmp++;
        if (spurious !== 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d active cycles want 0", spurious);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        lat_fixed = -1;
        do_req(1'b0, 32'h300, 32'd0, 2'd0, 1'b0, rd, hs, rs);
        n_cmp++;
        if (rd !== ref_load(32'h300, 2'd0, 1'b0)) begin
            n_bad++;
            $display("FAIL midreset_reload: got %h want %h", rd, ref_load(32'h300, 2'd0, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a, wd, exp_rd;
        logic [1:0]  size;
        logic        we, uns;
        int hs, rs, nb;
        rand_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            we = $urandom;
            uns = $urandom;
            size = $urandom;
            wd = $urandom;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                             : 32'h1000 + $urandom_range(0, 31);
            exp_rd = we ? 32'd0 : ref_load(a, size, uns);
            do_req(we, a, wd, size, uns, rd, hs, rs);
            if (we) ref_store(a, size, wd);
            nb = exp_nbeats(a, size);
            n_cmp++;
            if (beats.size() !== nb) begin
                n_bad++;
                $display("FAIL rnd_nbeats[%0d]: got %0d want %0d (a=%h size=%0d)", t, beats.size(), nb, a, size);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    n_cmp++;
                    if ({beats[k].we, beats[k].addr, beats[k].be} !== {we, exp_baddr(a, k), exp_be(a, size, k)}) begin
                        n_bad++;
                        $display("FAIL rnd_beat[%0d.%0d]: got we=%b a=%h be=%b want we=%b a=%h be=%b", t, k,
                                 beats[k].we, beats[k].addr, beats[k].be, we, exp_baddr(a, k), exp_be(a, size, k));
                    end
                    if (we) begin
                        n_cmp++;
                        if ((beats[k].wdata & {{8{beats[k].be[3]}}, {8{beats[k].be[2]}}, {8{beats[k].be[1]}}, {8{beats[k].be[0]}}})
                            !== exp_lanes(a, size, wd, k)) begin
                            n_bad++;
                            $display("FAIL rnd_wdata[%0d.%0d]: got %h want lanes %h", t, k,
                                     beats[k].wdata, exp_lanes(a, size, wd, k));
                        end
                    end
                end
            end
            n_cmp++;
            if (rd !== exp_rd) begin
                n_bad++;
                $display("FAIL rnd_rdata[%0d]: got %h want %h (we=%b a=%h size=%0d uns=%b)", t, rd, exp_rd, we, a, size, uns);
            end
            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_ready_in_resp[%0d]: got %b want 0", t, req_ready);
            end
            tick();
            n_cmp++;
            if (req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd_ready_after_resp[%0d]: got %b want 1", t, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_store();
        test_byte_store();
        test_byte_loads();
        test_misaligned_load();
        test_stall_split_store();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
